// File: rtl/audacq_fifo_pkg.sv
// Shared widths, dout field positions and the popped-word packing helper
// for the audio acquisition sample FIFO.
package audacq_fifo_pkg;

    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned SAMPLE_WIDTH = 24;
    localparam int unsigned VLD_BIT      = 31;
    localparam int unsigned OVF_BIT      = 30;
    localparam int unsigned UNF_BIT      = 29;

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [WORD_WIDTH-1:0]   word_t;

    typedef struct packed {
        logic vld;
        logic ovf;
        logic unf;
    } status_t;

    function automatic word_t make_word(input status_t st, input sample_t data);
        word_t w;
        w                     = '0;
        w[VLD_BIT]            = st.vld;
        w[OVF_BIT]            = st.ovf;
        w[UNF_BIT]            = st.unf;
        w[SAMPLE_WIDTH-1:0]   = data;
        return w;
    endfunction

endpackage

// File: rtl/audacq_fifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port
// whose output register resets so dout reads zero out of reset.
module audq_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Read-before-write: a same-address push+pop on a full FIFO returns the old entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd <= '0;
        end else if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/audacq_fifo.sv
// Circular sample FIFO between the acquisition stage and the bus read path,
// with sticky overflow/underflow reporting and a fill-level watermark.
module audacq_fifo
    import audacq_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WATERMARK  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                arrive,
    input  logic [23:0]         sample,
    input  logic                pop,
    input  logic                flush,
    output logic [31:0]         dout,
    output logic                dout_vld,
    output logic [DEPTH_LOG2:0] level,
    output logic                empty,
    output logic                full,
    output logic                wm
);

    localparam logic [DEPTH_LOG2:0] WM_LEVEL = WATERMARK[DEPTH_LOG2:0];

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                ovf;
    logic                unf;
    status_t             status;
    sample_t             rd_data;

    logic push_ok;
    logic pop_ok;
    logic ovf_evt;
    logic unf_evt;
    logic word_req;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign wm    = (level >= WM_LEVEL);

    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        word_req = 1'b0;
        if (!flush) begin
            word_req = pop;
            pop_ok   = pop & ~empty;
            unf_evt  = pop & empty;
            // A pop on a full FIFO frees the slot the push lands in.
            push_ok  = arrive & (~full | pop);
            ovf_evt  = arrive & full & ~pop;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            status   <= '0;
            dout_vld <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= word_req;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // The produced word reports pending plus same-cycle events, then the flags clear.
            if (word_req) begin
                status <= '{vld: pop_ok, ovf: ovf | ovf_evt, unf: unf | unf_evt};
                ovf    <= 1'b0;
                unf    <= 1'b0;
            end else begin
                ovf <= ovf | ovf_evt;
            end
        end
    end

    audq_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (SAMPLE_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rstn (rstn),
        .we   (push_ok),
        .wa   (wr_ptr[DEPTH_LOG2-1:0]),
        .wd   (sample),
        .re   (pop_ok),
        .ra   (rd_ptr[DEPTH_LOG2-1:0]),
        .rd   (rd_data)
    );

    assign dout = make_word(status, rd_data);

endmodule

// File: tb/tb_audacq_fifo.sv
// Scoreboard bench for audacq_fifo: a queue-based reference model predicts
// popped words and fill status; a negedge monitor compares.
module tb_audacq_fifo;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 1 << DL2;
    localparam int unsigned WMARK = 8;

    logic           clk;
    logic           rstn;
    logic           arrive;
    logic [23:0]    sample;
    logic           pop;
    logic           flush;
    logic [31:0]    dout;
    logic           dout_vld;
    logic [DL2:0]   level;
    logic           empty;
    logic           full;
    logic           wm;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [23:0] mq[$];
    logic [31:0] exp_q[$];
    bit          m_ovf;
    bit          m_unf;
    logic [23:0] m_last;
    bit          mon_en;

    audacq_fifo #(
        .DEPTH_LOG2 (DL2),
        .WATERMARK  (WMARK)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .arrive   (arrive),
        .sample   (sample),
        .pop      (pop),
        .flush    (flush),
        .dout     (dout),
        .dout_vld (dout_vld),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .wm       (wm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the reference model, applied with the inputs seen at the edge.
    task automatic model_step(input logic a, input logic [23:0] s, input logic p, input logic f);
        logic [31:0] w;
        if (f) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (p) begin
            if (mq.size() != 0) begin
                m_last = mq.pop_front();
                w = {1'b1, m_ovf, m_unf, 5'b0, m_last};
            end else begin
                w = {1'b0, m_ovf, 1'b1, 5'b0, m_last};
            end
            exp_q.push_back(w);
            m_ovf = 0;
            m_unf = 0;
        end
        if (a) begin
            if (mq.size() < DEPTH) mq.push_back(s);
            else m_ovf = 1;
        end
    endtask

    task automatic cycle(input logic a, input logic [23:0] s, input logic p, input logic f);
        arrive = a;
        sample = s;
        pop    = p;
        flush  = f;
        @(posedge clk);
        #1;
        model_step(a, s, p, f);
        arrive = 1'b0;
        pop    = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf  = 0;
        m_unf  = 0;
        m_last = '0;
    endtask

    always @(negedge clk) begin
        if (rstn && mon_en) begin
            chk("dout_vld", {31'b0, dout_vld}, {31'b0, exp_q.size() != 0});
            if (dout_vld && exp_q.size() != 0) begin
                chk("dout", dout, exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            chk("level", {27'b0, level}, mq.size());
            chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
            chk("full",  {31'b0, full},  {31'b0, mq.size() == DEPTH});
            chk("wm",    {31'b0, wm},    {31'b0, mq.size() >= WMARK});
        end
    end

    initial begin
        logic [23:0] r;
        rstn   = 1'b0;
        arrive = 1'b0;
        sample = '0;
        pop    = 1'b0;
        flush  = 1'b0;
        mon_en = 0;
        model_reset();

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_level", {27'b0, level}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_vld", {31'b0, dout_vld}, 32'd0);
        chk("rst_wm", {31'b0, wm}, 32'd0);
        rstn   = 1'b1;
        mon_en = 1;

        // Ordering
        for (int i = 1; i <= 5; i++) cycle(1'b1, 24'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("order_empty", {31'b0, empty}, 32'd1);

        // Overflow
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 24'($urandom()), 1'b0, 1'b0);
            if (i == 15) chk("full_after_16", {31'b0, full}, 32'd1);
        end
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Underflow
        cycle(1'b1, 24'h00ABCD, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("unf_word", dout, 32'h2000ABCD);
        cycle(1'b1, 24'h123456, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("unf_cleared", dout, 32'h80123456);

        // Watermark and wrap
        for (int i = 0; i < 7; i++) cycle(1'b1, 24'($urandom()), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 24'($urandom()), 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        chk("wm_level7", {27'b0, level}, 32'd7);
        while (mq.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) cycle(1'b1, 24'($urandom()), 1'b0, 1'b0);
        cycle(1'b1, 24'h0F0F0F, 1'b1, 1'b0);
        chk("full_pp_level", {27'b0, level}, 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush during push and pop
        for (int i = 0; i < 3; i++) cycle(1'b1, 24'($urandom()), 1'b0, 1'b0);
        cycle(1'b1, 24'h777777, 1'b1, 1'b1);
        chk("flush_level", {27'b0, level}, 32'd0);
        chk("flush_vld", {31'b0, dout_vld}, 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Async reset while a popped word is being presented
        cycle(1'b1, 24'h55AA55, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_vld", {31'b0, dout_vld}, 32'd1);
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("async_rst_vld", {31'b0, dout_vld}, 32'd0);
        chk("async_rst_dout", dout, 32'd0);
        chk("async_rst_level", {27'b0, level}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            r = 24'($urandom());
            cycle(($urandom_range(0, 99) < 50), r,
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 2));
        end

        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
